// File: rtl/apb_reg_pkg.sv
// Shared constants and types for the APB register slave.
// Covers the register map, the CTRL fields and the transfer FSM states.
package apb_reg_pkg;

    localparam logic [31:0] OFS_ID      = 32'h00;
    localparam logic [31:0] OFS_CTRL    = 32'h04;
    localparam logic [31:0] OFS_STATUS  = 32'h08;
    localparam logic [31:0] OFS_RSVD    = 32'h0C;
    localparam logic [31:0] OFS_SCRATCH = 32'h10;
    localparam logic [31:0] MAP_LIMIT   = 32'h40;

    localparam logic [31:0] ID_VALUE    = 32'hA9B0_0001;
    localparam int          NUM_SCRATCH = 12;

    localparam int CTRL_WAIT_LSB = 0;
    localparam int CTRL_WAIT_W   = 4;
    localparam int CTRL_CLR_ERR  = 8;

    // Word indices (PADDR[5:2]) of the fixed registers
    localparam logic [3:0] WORD_ID      = OFS_ID[5:2];
    localparam logic [3:0] WORD_CTRL    = OFS_CTRL[5:2];
    localparam logic [3:0] WORD_STATUS  = OFS_STATUS[5:2];
    localparam logic [3:0] WORD_SCRATCH = OFS_SCRATCH[5:2];

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] data;
        logic [3:0]  strb;
    } apb_req_t;

endpackage

// File: rtl/apb_reg_slave.sv
// APB slave with ID/CTRL/STATUS/scratch registers and programmable wait states.
// All bus outputs are registered; decode runs off the live bus in IDLE, the latched request in ACCESS.
module apb_reg_slave
    import apb_reg_pkg::*;
#(
    parameter int WIDTH_AD = 32,
    parameter int WIDTH_DA = 32
) (
    input  logic                axi_apb_clk,
    input  logic                axi_apb_sw_rst,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [WIDTH_AD-1:0] PADDR,
    input  logic [WIDTH_DA-1:0] PDATA,
    input  logic [3:0]          PSTRB,
    output logic                PREADY,
    output logic [WIDTH_DA-1:0] PRDATA,
    output logic                PSLVERR,
    output logic                err_irq
);

    state_t                         state, state_d;
    logic [CTRL_WAIT_W-1:0]         cnt, cnt_d;
    logic                           pready_d, latch, commit;
    logic [WIDTH_AD-1:0]            addr_q;
    apb_req_t                       req_q;

    logic [CTRL_WAIT_W-1:0]         ctrl_wait;
    logic [7:0]                     err_cnt;
    logic [NUM_SCRATCH-1:0][31:0]   scratch;

    logic                           pready_q, pslverr_q, err_irq_q;
    logic [WIDTH_DA-1:0]            prdata_q;

    logic [WIDTH_AD-1:0]            addr_s;
    logic                           wr_s, dec_err;
    logic [3:0]                     word_s, word_q;
    logic [31:0]                    rd_word;
    logic                           wr_commit, clr_err;

    // With WAIT=0 the response is loaded on the setup edge, before the request is latched
    always_comb begin
        addr_s  = (state == IDLE) ? PADDR  : addr_q;
        wr_s    = (state == IDLE) ? PWRITE : req_q.write;
        word_s  = addr_s[5:2];
        word_q  = addr_q[5:2];
        dec_err = (addr_s[1:0] != 2'b00)
               || (addr_s >= WIDTH_AD'(MAP_LIMIT))
               || (addr_s == WIDTH_AD'(OFS_RSVD))
               || (wr_s && ((addr_s == WIDTH_AD'(OFS_ID)) || (addr_s == WIDTH_AD'(OFS_STATUS))));
    end

    always_comb begin
        rd_word = '0;
        case (word_s)
            WORD_ID:     rd_word = ID_VALUE;
            WORD_CTRL:   rd_word[CTRL_WAIT_LSB +: CTRL_WAIT_W] = ctrl_wait;
            WORD_STATUS: rd_word[7:0] = err_cnt;
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++)
                    if (word_s == WORD_SCRATCH + 4'(i)) rd_word = scratch[i];
            end
        endcase
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        pready_d = 1'b0;
        latch    = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d  = ACCESS;
                    cnt_d    = ctrl_wait;
                    latch    = 1'b1;
                    pready_d = (ctrl_wait == '0);
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (pready_q) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end else if (cnt != '0) begin
                    cnt_d    = cnt - 1'b1;
                    pready_d = (cnt == CTRL_WAIT_W'(1));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An errored transfer never writes; pslverr_q is the error flag of the completing transfer
    assign wr_commit = commit && req_q.write && !pslverr_q;
    assign clr_err   = wr_commit && (word_q == WORD_CTRL) && req_q.strb[1] && req_q.data[CTRL_CLR_ERR];

    always_ff @(posedge axi_apb_clk) begin
        if (axi_apb_sw_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            req_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            err_irq_q <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pready_d && dec_err;
            prdata_q  <= (pready_d && !wr_s && !dec_err) ? rd_word : '0;
            err_irq_q <= (err_cnt != 8'd0);
            if (latch) begin
                addr_q      <= PADDR;
                req_q.write <= PWRITE;
                req_q.data  <= PDATA;
                req_q.strb  <= PSTRB;
            end
        end
    end

    always_ff @(posedge axi_apb_clk) begin
        if (axi_apb_sw_rst) begin
            ctrl_wait <= '0;
            err_cnt   <= '0;
            scratch   <= '0;
        end else begin
            if (wr_commit && (word_q == WORD_CTRL) && req_q.strb[0])
                ctrl_wait <= req_q.data[CTRL_WAIT_LSB +: CTRL_WAIT_W];
            if (clr_err)
                err_cnt <= '0;
            else if (commit && pslverr_q && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
            for (int i = 0; i < NUM_SCRATCH; i++)
                if (wr_commit && (word_q == WORD_SCRATCH + 4'(i)))
                    for (int b = 0; b < 4; b++)
                        if (req_q.strb[b]) scratch[i][b*8 +: 8] <= req_q.data[b*8 +: 8];
        end
    end

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;
    assign err_irq = err_irq_q;

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter WIDTH_AD, default 32, APB address width.
REQ-002 SHALL have parameter WIDTH_DA, default 32, APB data width; only 32 is supported.
REQ-003 SHALL have port axi_apb_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port axi_apb_sw_rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port PSEL, input, 1, slave select.
REQ-006 SHALL have port PENABLE, input, 1, access phase.
REQ-007 SHALL have port PWRITE, input, 1, 1 = write.
REQ-008 SHALL have port PADDR, input, WIDTH_AD, byte address.
REQ-009 SHALL have port PDATA, input, WIDTH_DA, write data.
REQ-010 SHALL have port PSTRB, input, 4, write byte lanes.
REQ-011 SHALL have port PREADY, output, 1, transfer complete.
REQ-012 SHALL have port PRDATA, output, WIDTH_DA, read data.
REQ-013 SHALL have port PSLVERR, output, 1, transfer error.
REQ-014 SHALL have port err_irq, output, 1, level interrupt; asserted while the error count is nonzero.

Function
REQ-015 SHALL implement the register map: 0x00 ID, RO, 32'hA9B0_0001; 0x04 CTRL, RW, [3:0] WAIT, [8] CLR_ERR (self-clearing, reads 0); 0x08 STATUS, RO, [7:0] ERR_CNT; 0x10-0x3C SCRATCH0-11, RW, 32 bits each.
REQ-016 SHALL run FSM IDLE -> ACCESS -> IDLE: IDLE moves to ACCESS on PSEL=1 and PENABLE=0 (setup phase), latching PADDR, PWRITE, PDATA and PSTRB, and loading the wait counter from CTRL.WAIT.
REQ-017 SHALL hold PREADY=0 in ACCESS while the counter is nonzero, decrementing it once per cycle; PREADY=1 for exactly one cycle when the counter is 0, then the FSM returns to IDLE.
REQ-018 SHALL therefore assert PREADY in the (WAIT+1)th access-phase cycle: WAIT=0 gives zero wait states, WAIT=15 gives 15.
REQ-019 SHALL derive PREADY, PRDATA and PSLVERR from registered state only, with no combinational path from APB inputs.
REQ-020 SHALL commit a write only in the PREADY cycle, updating each byte lane whose PSTRB bit is 1; PSTRB=0 is a legal no-op with no error.
REQ-021 SHALL drive PRDATA with the addressed register in the PREADY cycle of a read, and 0 in all other cycles; reads ignore PSTRB.
REQ-022 SHALL assert PSLVERR only in the PREADY cycle, when PADDR[1:0]!=0, PADDR>=0x40, PADDR is 0x0C, or the access is a write to ID or STATUS.
REQ-023 SHALL make an errored write change no register, and SHALL return PRDATA=0 on an errored read.
REQ-024 SHALL increment ERR_CNT on each PSLVERR, saturating at 255.
REQ-025 SHALL clear ERR_CNT on a CTRL write with PSTRB[1]=1 and PDATA[8]=1; if an error occurs in the same cycle, the clear wins.
REQ-026 SHALL register err_irq so that it follows ERR_CNT!=0 with a one-cycle lag.
REQ-027 SHALL apply a new CTRL.WAIT value from the next transfer onward; the current transfer's latched count is unaffected.
REQ-028 SHALL, if PSEL drops during ACCESS, abort to IDLE in the next cycle with no write, no PREADY and no error count.
REQ-029 SHALL ignore PSEL=1 with PENABLE=1 seen in IDLE (no setup phase seen); it is not a transfer.
REQ-030 SHALL accept back-to-back transfers: a setup phase in the cycle after PREADY is accepted.

Reset
REQ-031 SHALL, on axi_apb_sw_rst=1 at a clock edge, set the FSM to IDLE; set the counter, CTRL, ERR_CNT and all SCRATCH to 0; and set PREADY, PRDATA, PSLVERR and err_irq to 0 from the next cycle.
REQ-032 SHALL, on reset during ACCESS, abort the transfer with no register update; the first setup phase after reset release is accepted normally.

Structure
REQ-033 SHALL place register offsets, the ID value, the map limit 0x40, the CTRL field positions and the FSM state enum in a shared package apb_reg_pkg.
REQ-034 SHALL be a single module with no sub-module; expected size is 150-250 RTL lines.

Verification
REQ-035 Reset, then read 0x00 with WAIT=0 -> PREADY in the first access cycle, PRDATA=32'hA9B0_0001, PSLVERR=0.
REQ-036 Write 0x04=0x3, then write 0x10=0xDEADBEEF -> PREADY 3 cycles after the first access cycle; reading 0x10 returns 0xDEADBEEF.
REQ-037 Write 0x14=0xFFFFFFFF with PSTRB=4'b0101 over 0x00000000 -> reading back gives 0x00FF00FF.
REQ-038 Read 0x40, read 0x12, write 0x00 -> PSLVERR=1 in each PREADY cycle, ID unchanged, STATUS=3, err_irq=1.
REQ-039 Write 0x04 with data 0x100 -> STATUS=0 and err_irq=0 one cycle later; 300 further errors -> STATUS=255.
REQ-040 Start a write to 0x18 with WAIT=5 and assert axi_apb_sw_rst in the 2nd access cycle -> no PREADY, 0x18 reads 0, CTRL=0.
